sram_port0_ctrl: RTL and testbench
==================================

Name: sram_port0_ctrl

Overview:
- Bus-side initiator that drives the RW port 0 of the team's `sram` macro (registered inputs on posedge, `dout0` updated on negedge).
- Converts a valid/ready request channel into single-cycle macro accesses.
- Captures `dout0` into a response FIFO with back-pressure.
- Sits between the core/TL-UL data-memory adapter and the SRAM instance.

Parameters:
- NUM_WMASKS, 4, byte lanes per word; matches macro.
- DATA_WIDTH, 32, word width; must equal 8*NUM_WMASKS.
- ADDR_WIDTH, 10, macro word-address width.
- RAM_DEPTH, 1<<ADDR_WIDTH, words swept by optional init.
- RSP_DEPTH, 2, response FIFO entries (>=2).

Ports:
- clk_i  in  1  clock; also feeds macro clk0.
- rst_i  in  1  reset, asynchronous, active-high.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_we_i  in  1  1=write, 0=read.
- req_addr_i  in  ADDR_WIDTH+2  byte address.
- req_be_i  in  NUM_WMASKS  write byte enables.
- req_wdata_i  in  DATA_WIDTH  write data.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response accept.
- rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err_o  out  1  misaligned access.
- init_done_o  out  1  controller accepting requests.
- sram_csb0_o  out  1  macro chip select, active low.
- sram_web0_o  out  1  macro write enable, active low.
- sram_wmask0_o  out  NUM_WMASKS  macro write mask.
- sram_addr0_o  out  ADDR_WIDTH  macro word address.
- sram_din0_o  out  DATA_WIDTH  macro write data.
- sram_dout0_i  in  DATA_WIDTH  macro read data.

Behaviour:
- Reset values: req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, sram_csb0_o=1, sram_web0_o=1, others 0. FIFO empty, inflight cleared.
- While rst_i is high, sram_csb0_o=1 regardless of inputs.
- Handshake:
  - A request is accepted when req_valid_i && req_ready_o at posedge T.
  - Responses are returned in order, one per accepted request.
  - A response transfers when rsp_valid_o && rsp_ready_i.
- Macro drive is combinational from the accepted request in the same cycle, so the macro samples it at posedge T:
  - csb0 = !(accept && aligned).
  - web0 = !req_we_i.
  - wmask0 = req_be_i.
  - addr0 = req_addr_i[ADDR_WIDTH+1:2].
  - din0 = req_wdata_i.
  - When idle: csb0=1, web0=1.
- Misaligned request (req_addr_i[1:0]!=0): accepted, no macro access (csb0 stays 1), response has rsp_err_o=1 and rdata=0.
- Latency:
  - inflight flag (plus we/err) registers at T.
  - At posedge T+1 the FIFO pushes {rdata,err}. rdata = sram_dout0_i for aligned reads, else 0.
  - rsp_valid_o is high from cycle T+1 (FIFO head, registered outputs).
  - Read-to-response latency is 1 cycle.
- req_ready_o = init_done_o && (fifo_count + inflight - pop) < RSP_DEPTH, where pop = rsp_valid_o && rsp_ready_i.
  - This is a combinational path from rsp_ready_i to req_ready_o.
  - With rsp_ready_i held high, throughput is 1 request/cycle.
- FIFO full with no pop: req_ready_o=0. No request may be lost or overwritten.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- Write with req_be_i=0: macro access issued with mask 0 (no-op); normal response.
- Reset asserted mid-operation: FIFO, inflight and FSM clear asynchronously. Pending responses are discarded. Partially issued writes are not retried.

Optional Feature:
SRAM_CTRL_ZERO_INIT_EN:
- Defined:
  - FSM S_INIT -> S_IDLE. Reset enters S_INIT with counter=0 and init_done_o=0.
  - In S_INIT, each cycle drives csb0=0, web0=0, wmask0=all ones, din0=0, addr0=counter; counter increments.
  - After the write to RAM_DEPTH-1, the FSM moves to S_IDLE and init_done_o=1 on the next cycle.
  - The sweep takes exactly RAM_DEPTH cycles; no responses are produced.
- Undefined:
  - No FSM; init_done_o=0 in reset and 1 from the first clock edge after reset release.
  - Memory contents are uninitialised.

Test Plan:
- Reset, hold 3 cycles -> csb0=1, web0=1, rsp_valid_o=0, req_ready_o=0 during reset. Without macro, req_ready_o=1 after the first edge post-release.
- Write addr 0x010 data 0xDEADBEEF be 4'hF, then read 0x010 -> macro addr0=4 with web0=0 then 1; read response rdata=0xDEADBEEF one cycle after accept. Write response rdata=0, err=0.
- Partial write be=4'b0010 data 0x0000AB00 over 0xDEADBEEF, then read -> rdata=0xDEADABEF.
- rsp_ready_i=0, issue 4 reads -> exactly 2 accepted, then req_ready_o=0 and csb0 stays 1. Raise rsp_ready_i -> responses in order, then 1 accept/cycle resumes.
- Read addr 0x013 -> no macro access; rsp_err_o=1, rdata=0.
- With SRAM_CTRL_ZERO_INIT_EN, ADDR_WIDTH=4: after reset, 16 zero-writes to addr 0..15; init_done_o rises at cycle 16; read any address returns 0. Reset asserted at sweep cycle 5 -> csb0=1 immediately and the sweep restarts at 0.

Source files
------------

// File: rtl/sram_port0_ctrl.sv
// -----------------------------------------------------------------------------
// sram_port0_ctrl
//
// Bus-side initiator for RW port 0 of the sram macro. The macro registers its
// inputs on posedge clk and updates dout0 on the following negedge, so a
// request accepted at posedge T has its read data available at posedge T+1.
//
// Each accepted request becomes one single-cycle macro access (none if
// misaligned). Exactly one response per request is pushed into a small
// response FIFO one cycle after acceptance, and responses leave in order.
//
// Handshake rules (both channels): a transfer happens on a posedge where
// valid && ready are both high. Valid, once raised by a source, is not
// expected to depend on ready. req_ready_o depends combinationally on
// rsp_ready_i so that a full FIFO being drained still sustains one request
// per cycle.
//
// Optional feature macro: SRAM_CTRL_ZERO_INIT_EN
//   defined   - after reset a sweep writes zero to words 0..RAM_DEPTH-1, one
//               per cycle, before init_done_o rises and requests are taken.
//   undefined - no sweep; init_done_o rises on the first edge after reset.
//
// Ports:
//   clk_i, rst_i          clock (also macro clk0), async active-high reset
//   req_*                 request channel: valid/ready, we, byte addr, be, wdata
//   rsp_*                 response channel: valid/ready, rdata, err
//   init_done_o           controller is accepting requests
//   sram_*0_o / _i        macro port 0: csb0, web0, wmask0, addr0, din0, dout0
// -----------------------------------------------------------------------------
module sram_port0_ctrl #(
    parameter int NUM_WMASKS = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH+1:0] req_addr_i,
    input  logic [NUM_WMASKS-1:0] req_be_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  init_done_o,
    output logic                  sram_csb0_o,
    output logic                  sram_web0_o,
    output logic [NUM_WMASKS-1:0] sram_wmask0_o,
    output logic [ADDR_WIDTH-1:0] sram_addr0_o,
    output logic [DATA_WIDTH-1:0] sram_din0_o,
    input  logic [DATA_WIDTH-1:0] sram_dout0_i
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W = $clog2(RSP_DEPTH);

    // Elaboration-time parameter sanity.
    if (DATA_WIDTH != 8 * NUM_WMASKS || RSP_DEPTH < 2 ||
        RAM_DEPTH < 1 || RAM_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_params
        $error("sram_port0_ctrl: inconsistent parameters");
    end

    // -------------------------------------------------------------------------
    // Request side
    // -------------------------------------------------------------------------
    logic                  accept;
    logic                  aligned;
    logic                  pop;
    logic                  push;
    logic [CNT_W:0]        occupancy;

    // Response FIFO state
    logic [CNT_W-1:0]      fifo_count;
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [DATA_WIDTH-1:0] fifo_data [RSP_DEPTH];
    logic                  fifo_err  [RSP_DEPTH];

    // One request in the macro pipeline (accepted last cycle, response not yet
    // pushed). A request carries its own slot reservation through here.
    logic                  inflight;
    logic                  inflight_we;
    logic                  inflight_err;
    logic [DATA_WIDTH-1:0] push_rdata;

    assign aligned = (req_addr_i[1:0] == 2'b00);
    assign pop     = rsp_valid_o && rsp_ready_i;
    assign accept  = req_valid_i && req_ready_o;
    assign push    = inflight;

    // Slots committed once this cycle's pop retires; a new request is only
    // taken if its response is guaranteed a slot at the next edge.
    assign occupancy   = {1'b0, fifo_count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
    assign req_ready_o = init_done_o && (occupancy < (CNT_W+1)'(RSP_DEPTH));

    // Only aligned reads return macro data; writes and errors return zero.
    assign push_rdata = (!inflight_we && !inflight_err) ? sram_dout0_i : '0;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // -------------------------------------------------------------------------
    // Initialisation control
    // -------------------------------------------------------------------------
`ifdef SRAM_CTRL_ZERO_INIT_EN
    typedef enum logic {
        S_INIT = 1'b0,
        S_IDLE = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(RAM_DEPTH - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] init_cnt;

    // Sweep FSM: one zero-write per cycle; init_done_o rises on the edge that
    // completes the write to the last word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_INIT;
            init_cnt    <= '0;
            init_done_o <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    init_cnt <= init_cnt + ADDR_WIDTH'(1);
                    if (init_cnt == LAST_WORD) begin
                        state       <= S_IDLE;
                        init_done_o <= 1'b1;
                    end
                end
                S_IDLE: begin
                    init_done_o <= 1'b1;
                end
                default: begin
                    state       <= S_INIT;
                    init_cnt    <= '0;
                    init_done_o <= 1'b0;
                end
            endcase
        end
    end
`else
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            init_done_o <= 1'b0;
        end else begin
            init_done_o <= 1'b1;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Macro drive: combinational from the request accepted this cycle, so the
    // macro samples it on the same edge that accepts the request.
    // -------------------------------------------------------------------------
    always_comb begin
        sram_csb0_o   = 1'b1;
        sram_web0_o   = 1'b1;
        sram_wmask0_o = '0;
        sram_addr0_o  = '0;
        sram_din0_o   = '0;
`ifdef SRAM_CTRL_ZERO_INIT_EN
        if (state == S_INIT) begin
            sram_csb0_o   = 1'b0;
            sram_web0_o   = 1'b0;
            sram_wmask0_o = '1;
            sram_addr0_o  = init_cnt;
            sram_din0_o   = '0;
        end else
`endif
        if (accept && aligned) begin
            sram_csb0_o   = 1'b0;
            sram_web0_o   = !req_we_i;
            sram_wmask0_o = req_be_i;
            sram_addr0_o  = req_addr_i[ADDR_WIDTH+1:2];
            sram_din0_o   = req_wdata_i;
        end
        // The chip select must be inactive throughout reset, independent of
        // whatever the sweep state or request inputs look like.
        if (rst_i) begin
            sram_csb0_o = 1'b1;
            sram_web0_o = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Inflight tracking and FIFO pointers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inflight     <= 1'b0;
            inflight_we  <= 1'b0;
            inflight_err <= 1'b0;
            fifo_count   <= '0;
            head         <= '0;
            tail         <= '0;
        end else begin
            inflight     <= accept;
            inflight_we  <= accept && req_we_i;
            inflight_err <= accept && !aligned;
            if (push) begin
                tail <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FIFO storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data[tail] <= push_rdata;
            fifo_err[tail]  <= inflight_err;
        end
    end

    assign rsp_valid_o = (fifo_count != '0);
    assign rsp_rdata_o = rsp_valid_o ? fifo_data[head] : '0;
    assign rsp_err_o   = rsp_valid_o ? fifo_err[head]  : 1'b0;

endmodule

// File: tb/tb_sram_port0_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_port0_ctrl
//
// Bench for sram_port0_ctrl with a behavioural sram port-0 macro model
// (inputs registered on posedge, dout0 updated on negedge). Expected responses
// come from a word-array reference memory updated in request order; the
// scoreboard compares them against responses as they leave the DUT.
// Inputs are driven 1 time unit after posedge; outputs are sampled on negedge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sram_port0_ctrl;

    localparam int NW        = 4;
    localparam int DW        = 32;
    localparam int AW        = 4;
    localparam int DEPTH     = 1 << AW;
    localparam int RSP_DEPTH = 2;

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- DUT signals
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW+1:0] req_addr;
    logic [NW-1:0] req_be;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          init_done;
    logic          sram_csb0;
    logic          sram_web0;
    logic [NW-1:0] sram_wmask0;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_din0;
    logic [DW-1:0] sram_dout0;

    sram_port0_ctrl #(
        .NUM_WMASKS(NW),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .RAM_DEPTH (DEPTH),
        .RSP_DEPTH (RSP_DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_addr_i   (req_addr),
        .req_be_i     (req_be),
        .req_wdata_i  (req_wdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err),
        .init_done_o  (init_done),
        .sram_csb0_o  (sram_csb0),
        .sram_web0_o  (sram_web0),
        .sram_wmask0_o(sram_wmask0),
        .sram_addr0_o (sram_addr0),
        .sram_din0_o  (sram_din0),
        .sram_dout0_i (sram_dout0)
    );

    // ---------------------------------------------------------------- macro model
    logic [DW-1:0] mem [DEPTH];
    logic          m_csb = 1'b1;
    logic          m_web = 1'b1;
    logic [NW-1:0] m_mask;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din;

    always @(posedge clk) begin
        m_csb  <= sram_csb0;
        m_web  <= sram_web0;
        m_mask <= sram_wmask0;
        m_addr <= sram_addr0;
        m_din  <= sram_din0;
    end

    always @(negedge clk) begin
        if (!m_csb) begin
            if (!m_web) begin
                for (int i = 0; i < NW; i++) begin
                    if (m_mask[i]) mem[m_addr][i*8 +: 8] = m_din[i*8 +: 8];
                end
            end else begin
                sram_dout0 = mem[m_addr];
            end
        end
    end

    // ---------------------------------------------------------------- checking
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- reference model
    logic [DW-1:0] ref_mem [DEPTH];

    // Applies one request to the reference memory; returns {err, rdata}.
    function automatic logic [DW:0] model_access(input logic we, input logic [AW+1:0] a,
                                                 input logic [NW-1:0] be, input logic [DW-1:0] wd);
        int w;
        if (a[1:0] != 2'b00) return {1'b1, {DW{1'b0}}};
        w = int'(a >> 2);
        if (we) begin
            for (int i = 0; i < NW; i++) begin
                if (be[i]) ref_mem[w][i*8 +: 8] = wd[i*8 +: 8];
            end
            return '0;
        end
        return {1'b0, ref_mem[w]};
    endfunction

    // ---------------------------------------------------------------- scoreboard
    logic [DW:0] exp_q[$];
    int          n_acc = 0;

    always @(negedge clk) begin : scoreboard
        logic [DW:0] e;
        if (!rst && init_done) begin
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_err", rsp_err, e[DW]);
                    check("rsp_rdata", rsp_rdata, e[DW-1:0]);
                end
            end
            if (req_valid && req_ready) begin
                n_acc++;
                if (req_addr[1:0] == 2'b00) begin
                    check("acc_csb0", sram_csb0, 1'b0);
                    check("acc_web0", sram_web0, !req_we);
                    check("acc_addr0", sram_addr0, req_addr[AW+1:2]);
                    check("acc_wmask0", sram_wmask0, req_be);
                    check("acc_din0", sram_din0, req_wdata);
                end else begin
                    check("misal_csb0", sram_csb0, 1'b1);
                end
                exp_q.push_back(model_access(req_we, req_addr, req_be, req_wdata));
            end else begin
                check("idle_csb0", sram_csb0, 1'b1);
            end
        end
    end

    // ---------------------------------------------------------------- driver tasks
    logic          last_csb0;
    logic          last_web0;
    logic [AW-1:0] last_addr0;

    task automatic drive_idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_be    = '0;
        req_wdata = '0;
    endtask

    // Presents one request and returns just after the edge that accepts it.
    task automatic do_req(input logic we, input logic [AW+1:0] a,
                          input logic [NW-1:0] be, input logic [DW-1:0] d);
        int waited;
        waited    = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_be    = be;
        req_wdata = d;
        @(negedge clk);
        while (!req_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!req_ready) check("req_accept_timeout", req_ready, 1'b1);
        last_csb0  = sram_csb0;
        last_web0  = sram_web0;
        last_addr0 = sram_addr0;
        @(posedge clk); #1;
        drive_idle();
    endtask

    // Single response, FIFO otherwise empty, rsp_ready high: not visible in the
    // cycle after acceptance, visible one edge later.
    task automatic expect_rsp(input string tag, input logic [DW-1:0] rd, input logic err);
        @(negedge clk);
        check({tag, "_early"}, rsp_valid, 1'b0);
        @(negedge clk);
        check({tag, "_valid"}, rsp_valid, 1'b1);
        check({tag, "_rdata"}, rsp_rdata, rd);
        check({tag, "_err"}, rsp_err, err);
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_left", exp_q.size(), 0);
        @(negedge clk);
        check("drain_valid", rsp_valid, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic wait_init();
        int n;
        n = 0;
        while (!init_done && n < DEPTH + 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("init_done_timeout", init_done, 1'b1);
    endtask

    // ---------------------------------------------------------------- watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- stimulus
    int  acc0;
    bit  rand_done;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = $urandom();
`ifdef SRAM_CTRL_ZERO_INIT_EN
            ref_mem[i] = '0;
`else
            ref_mem[i] = mem[i];
`endif
        end

        // Reset held 3 cycles with an active request on the inputs.
        rst       = 1'b1;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 'h10;
        req_be    = '1;
        req_wdata = '1;
        repeat (3) begin
            @(negedge clk);
            check("rst_csb0", sram_csb0, 1'b1);
            check("rst_web0", sram_web0, 1'b1);
            check("rst_rsp_valid", rsp_valid, 1'b0);
            check("rst_req_ready", req_ready, 1'b0);
            check("rst_rsp_rdata", rsp_rdata, 0);
            check("rst_rsp_err", rsp_err, 1'b0);
            check("rst_init_done", init_done, 1'b0);
        end
        @(posedge clk); #1;
        drive_idle();
        rsp_ready = 1'b1;
        rst       = 1'b0;

`ifdef SRAM_CTRL_ZERO_INIT_EN
        // Partial sweep, then reset at sweep cycle 5.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("sweep1_csb0", sram_csb0, 1'b0);
            check("sweep1_addr0", sram_addr0, i);
        end
        #2 rst = 1'b1;
        #1;
        check("sweep_rst_csb0", sram_csb0, 1'b1);
        check("sweep_rst_done", init_done, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            check("sweep_csb0", sram_csb0, 1'b0);
            check("sweep_web0", sram_web0, 1'b0);
            check("sweep_addr0", sram_addr0, i);
            check("sweep_wmask0", sram_wmask0, {NW{1'b1}});
            check("sweep_din0", sram_din0, 0);
            check("sweep_init_done", init_done, 1'b0);
            check("sweep_rsp_valid", rsp_valid, 1'b0);
        end
        @(negedge clk);
        check("init_done_rise", init_done, 1'b1);
        check("init_ready", req_ready, 1'b1);
        @(posedge clk); #1;
        do_req(1'b0, 'h24, '1, '0);
        expect_rsp("init_zero_rd", 32'h0, 1'b0);
`else
        @(negedge clk);
        check("pre_edge_ready", req_ready, 1'b0);
        check("pre_edge_init_done", init_done, 1'b0);
        @(negedge clk);
        check("post_edge_init_done", init_done, 1'b1);
        check("post_edge_ready", req_ready, 1'b1);
        @(posedge clk); #1;
`endif

        // Full write then read back.
        do_req(1'b1, 'h010, 4'hF, 32'hDEADBEEF);
        check("wr_addr0", last_addr0, 4);
        check("wr_web0", last_web0, 1'b0);
        expect_rsp("wr_rsp", 32'h0, 1'b0);
        do_req(1'b0, 'h010, 4'h0, 32'h0);
        check("rd_addr0", last_addr0, 4);
        check("rd_web0", last_web0, 1'b1);
        expect_rsp("rd_rsp", 32'hDEADBEEF, 1'b0);

        // Partial write of byte lane 1.
        do_req(1'b1, 'h010, 4'b0010, 32'h0000AB00);
        expect_rsp("pwr_rsp", 32'h0, 1'b0);
        do_req(1'b0, 'h010, 4'h0, 32'h0);
        expect_rsp("prd_rsp", 32'hDEADABEF, 1'b0);

        // Misaligned read: no macro access, error response.
        do_req(1'b0, 'h013, 4'h0, 32'h0);
        check("misal_last_csb0", last_csb0, 1'b1);
        expect_rsp("misal_rsp", 32'h0, 1'b1);

        // Write with no byte enables leaves the word unchanged.
        do_req(1'b1, 'h010, 4'h0, 32'hFFFFFFFF);
        check("be0_csb0", last_csb0, 1'b0);
        expect_rsp("be0_wr_rsp", 32'h0, 1'b0);
        do_req(1'b0, 'h010, 4'h0, 32'h0);
        expect_rsp("be0_rd_rsp", 32'hDEADABEF, 1'b0);

        // Back-pressure: with rsp_ready low only RSP_DEPTH reads get in.
        rsp_ready = 1'b0;
        acc0      = n_acc;
        fork
            begin
                for (int k = 0; k < 4; k++) do_req(1'b0, 6'(k * 4), '0, '0);
            end
            begin
                repeat (6) @(negedge clk);
                check("bp_accepts", n_acc - acc0, RSP_DEPTH);
                check("bp_ready", req_ready, 1'b0);
                check("bp_rsp_valid", rsp_valid, 1'b1);
                check("bp_csb0", sram_csb0, 1'b1);
                @(posedge clk); #1;
                rsp_ready = 1'b1;
            end
        join
        wait_drain();

        // Throughput: rsp_ready held high sustains one request per cycle.
        acc0 = n_acc;
        for (int k = 0; k < 8; k++) begin
            req_valid = 1'b1;
            req_we    = 1'b0;
            req_addr  = {4'($urandom_range(0, DEPTH - 1)), 2'b00};
            req_be    = '0;
            req_wdata = '0;
            @(negedge clk);
            check("tput_ready", req_ready, 1'b1);
            @(posedge clk); #1;
        end
        drive_idle();
        check("tput_accepts", n_acc - acc0, 8);
        wait_drain();

        // Reset in the middle of pending responses discards them.
        rsp_ready = 1'b0;
        do_req(1'b0, 'h004, '0, '0);
        do_req(1'b0, 'h008, '0, '0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_rsp_valid", rsp_valid, 1'b0);
        check("midrst_csb0", sram_csb0, 1'b1);
        check("midrst_ready", req_ready, 1'b0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rsp_ready = 1'b1;
`ifdef SRAM_CTRL_ZERO_INIT_EN
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`endif
        wait_init();
        @(negedge clk);
        check("postrst_rsp_valid", rsp_valid, 1'b0);
        @(posedge clk); #1;

        // Randomized traffic with random response back-pressure.
        rand_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    logic [AW+1:0] a;
                    a = {4'($urandom_range(0, DEPTH - 1)), 2'b00};
                    if ($urandom_range(0, 99) < 15) a[1:0] = 2'($urandom_range(1, 3));
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                    do_req(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom());
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rsp_ready = 1'b1;
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
